// File: rtl/quick_add_pkg.sv
// Shared types and constants for the Quick Add score display path.
// Holds the converter state encoding, default widths and BCD correction constants.
package quick_add_pkg;

  // One-hot so Busy/Done decode from a single state flop each.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    CONV = 3'b010,
    DONE = 3'b100
  } state_t;

  localparam int SCORE_W        = 8;
  localparam int SCORE_DIGITS   = 3;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_OFFSET = 3;

  // True when d decimal digits can represent every w-bit unsigned value.
  function automatic bit digits_cover(input int w, input int d);
    longint pow10;
    longint max_bin;
    pow10 = 1;
    for (int i = 0; i < d; i++) pow10 = pow10 * 10;
    max_bin = (longint'(1) << w) - 1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more.
// The corrected value never exceeds 12, so 4 bits always suffice.
module bcd_add3
  import quick_add_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'(BCD_ADJ_THRESH)) ? nibble + 4'(BCD_ADJ_OFFSET) : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, with start/done handshake.
// Leading-zero blank mask is built only when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
  import quick_add_pkg::*;
#(
  parameter int W = SCORE_W,
  parameter int D = SCORE_DIGITS
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [W-1:0]     Bin,
  output logic             Busy,
  output logic             Done,
  output logic [4*D-1:0]   Digits,
  output logic [D-1:0]     Blank
);

  localparam int SR_W  = 4*D + W;
  localparam int CNT_W = $clog2(W + 1);

  generate
    if (!digits_cover(W, D)) begin : g_bad_digits
      $error("bin2bcd_seq: D=%0d digits cannot hold a %0d-bit value", D, W);
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [SR_W-1:0]  shreg;
  logic [SR_W-1:0]  adj_reg;
  logic [SR_W-1:0]  shifted;
  logic             last_shift;

  // Correct every BCD nibble in parallel; the binary field passes through untouched.
  generate
    for (genvar i = 0; i < D; i++) begin : g_adj
      bcd_add3 u_add3 (
        .nibble   (shreg[W + 4*i +: 4]),
        .adjusted (adj_reg[W + 4*i +: 4])
      );
    end
  endgenerate

  assign adj_reg[W-1:0] = shreg[W-1:0];
  assign shifted        = adj_reg << 1;
  assign last_shift     = (count == CNT_W'(1));

  assign Busy = (state == CONV);
  assign Done = (state == DONE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      count  <= '0;
      shreg  <= '0;
      Digits <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            shreg <= {{(4*D){1'b0}}, Bin};
            count <= CNT_W'(W);
            state <= CONV;
          end else begin
            state <= IDLE;
          end
        end
        CONV: begin
          shreg <= shifted;
          count <= count - CNT_W'(1);
          if (last_shift) begin
            Digits <= shifted[SR_W-1:W];
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  localparam logic [D-1:0] BLANK_RST = {D{1'b1}} << 1;

  logic [D-1:0] blank_next;

  // A digit blanks only if it and everything above it are zero; digit 0 always shows.
  always_comb begin
    logic zero_above;
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      zero_above    = zero_above & (shifted[W + 4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Blank <= BLANK_RST;
    end else if (state == CONV && last_shift) begin
      Blank <= blank_next;
    end
  end
`else
  assign Blank = '0;
`endif

endmodule
